// File: rtl/cmp_pkg.sv
// Shared types and encodings for the comparator error monitor family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cmp_mon_state_t;

  // Relation triples are ordered {EQ,GT,LT}
  localparam logic [2:0] REL_EQ = 3'b100;
  localparam logic [2:0] REL_GT = 3'b010;
  localparam logic [2:0] REL_LT = 3'b001;

  // A legal comparator output asserts exactly one of EQ/GT/LT
  function automatic logic rel_is_legal(input logic [2:0] rel);
    return (rel == REL_EQ) || (rel == REL_GT) || (rel == REL_LT);
  endfunction

endpackage

// File: rtl/cmp_exact_ref.sv
// Exact unsigned {EQ,GT,LT} relation of two operands; golden model.
// Latency: purely combinational.
// Backpressure: none.
module cmp_exact_ref
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [2:0]       rel_o
);

  // Pick the single relation that holds between a and b
  always_comb begin
    rel_o = REL_LT;
    if (a_i == b_i) begin
      rel_o = REL_EQ;
    end else if (a_i > b_i) begin
      rel_o = REL_GT;
    end
  end

endmodule

// File: rtl/cmp_error_monitor.sv
// Counts mismatching and non-one-hot comparator outputs over a run of N pairs.
// Latency: pair accepted in cycle t is reflected in the counters from cycle t+2.
// Backpressure: in_ready high only while the run still needs pairs; full throughput.
module cmp_error_monitor
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             EQ,
  input  logic             GT,
  input  logic             LT,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  cmp_mon_state_t   state_q, state_d;
  logic [CNT_W-1:0] num_q, acc_q;
  logic             s1_vld_q, s2_vld_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_rel_q;
  logic [2:0]       exact_rel;
  logic [CNT_W-1:0] total_q, total_d, err_q, err_d, ill_q, ill_d;
  logic             fe_vld_q, fe_vld_d;
  logic [WIDTH-1:0] fe_a_q, fe_a_d, fe_b_q, fe_b_d;
  logic             accept, last_accept, start_ok, mismatch;

  assign in_ready    = (state_q == RUN);
  assign accept      = in_valid && in_ready;
  // num_q is never zero in RUN, so the subtraction cannot underflow there
  assign last_accept = accept && (acc_q == num_q - CNT_W'(1));
  assign start_ok    = (state_q == IDLE) && start;

  cmp_exact_ref #(.WIDTH(WIDTH)) u_exact (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .rel_o(exact_rel)
  );

  assign mismatch = (s1_rel_q != exact_rel);

  // Run sequencing: next state plus busy/done decode
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (num_samples != '0) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1_vld_q && !s2_vld_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating statistics and sticky first-mismatch capture
  always_comb begin
    total_d  = total_q;
    err_d    = err_q;
    ill_d    = ill_q;
    fe_vld_d = fe_vld_q;
    fe_a_d   = fe_a_q;
    fe_b_d   = fe_b_q;
    if (start_ok) begin
      total_d  = '0;
      err_d    = '0;
      ill_d    = '0;
      fe_vld_d = 1'b0;
      fe_a_d   = '0;
      fe_b_d   = '0;
    end else if (s1_vld_q) begin
      if (!(&total_q)) total_d = total_q + CNT_W'(1);
      if (mismatch && !(&err_q)) err_d = err_q + CNT_W'(1);
      if (!rel_is_legal(s1_rel_q) && !(&ill_q)) ill_d = ill_q + CNT_W'(1);
      if (mismatch && !fe_vld_q) begin
        fe_vld_d = 1'b1;
        fe_a_d   = s1_a_q;
        fe_b_d   = s1_b_q;
      end
    end
  end

  // State, run bookkeeping, pipeline and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      acc_q    <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_rel_q <= '0;
      total_q  <= '0;
      err_q    <= '0;
      ill_q    <= '0;
      fe_vld_q <= 1'b0;
      fe_a_q   <= '0;
      fe_b_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        num_q <= num_samples;
        acc_q <= '0;
      end else if (accept) begin
        acc_q <= acc_q + CNT_W'(1);
      end
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      if (accept) begin
        s1_a_q   <= A;
        s1_b_q   <= B;
        s1_rel_q <= {EQ, GT, LT};
      end
      total_q  <= total_d;
      err_q    <= err_d;
      ill_q    <= ill_d;
      fe_vld_q <= fe_vld_d;
      fe_a_q   <= fe_a_d;
      fe_b_q   <= fe_b_d;
    end
  end

  assign total_cnt       = total_q;
  assign err_cnt         = err_q;
  assign illegal_cnt     = ill_q;
  assign first_err_valid = fe_vld_q;
  assign first_err_a     = fe_a_q;
  assign first_err_b     = fe_b_q;

endmodule

// File: tb/tb_cmp_error_monitor.sv
// Scoreboard bench for cmp_error_monitor with directed and random runs.
// Latency: checks done timing relative to first accept and start.
// Backpressure: stimulus waits on in_ready with a bounded budget.
module tb_cmp_error_monitor;

  localparam int W  = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0, B = '0;
  logic          EQ = 1'b0, GT = 1'b0, LT = 1'b0;
  logic          busy, done;
  logic [CW-1:0] total_cnt, err_cnt, illegal_cnt;
  logic          first_err_valid;
  logic [W-1:0]  first_err_a, first_err_b;

  cmp_error_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .EQ(EQ), .GT(GT), .LT(LT), .busy(busy), .done(done),
    .total_cnt(total_cnt), .err_cnt(err_cnt), .illegal_cnt(illegal_cnt),
    .first_err_valid(first_err_valid), .first_err_a(first_err_a),
    .first_err_b(first_err_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    longint unsigned total, err, ill;
    bit              fev;
    logic [W-1:0]    fa, fb;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state for the run in progress
  longint unsigned m_total, m_err, m_ill;
  bit              m_fev;
  logic [W-1:0]    m_fa, m_fb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_total = 0; m_err = 0; m_ill = 0; m_fev = 0; m_fa = '0; m_fb = '0;
  endtask

  task automatic model_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] t);
    logic [2:0] ex;
    ex = {a == b, a > b, a < b};
    m_total++;
    if (t != ex) begin
      m_err++;
      if (!m_fev) begin m_fev = 1; m_fa = a; m_fb = b; end
    end
    if ($countones(t) != 1) m_ill++;
  endtask

  task automatic push_exp();
    exp_t e;
    e.total = m_total; e.err = m_err; e.ill = m_ill;
    e.fev = m_fev; e.fa = m_fa; e.fb = m_fb;
    exp_q.push_back(e);
  endtask

  // Offer one pair; returns the cycle number in which it was accepted
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] t,
                      output int acc_cyc);
    bit got;
    got = 0; acc_cyc = -1;
    A = a; B = b; {EQ, GT, LT} = t; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (got) begin
      acc_cyc = cyc;
      model_pair(a, b, t);
    end else begin
      check("send_timeout", 0, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [CW-1:0] n, output int st_cyc);
    start = 1'b1; num_samples = n;
    @(negedge clk);
    st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
    if (dc < 0) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Monitor: every done pulse must match the oldest queued run summary
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_total",   total_cnt,       e.total);
        check("sb_err",     err_cnt,         e.err);
        check("sb_illegal", illegal_cnt,     e.ill);
        check("sb_fev",     first_err_valid, e.fev);
        check("sb_fa",      first_err_a,     e.fa);
        check("sb_fb",      first_err_b,     e.fb);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, dc, a0, ac, n;
    logic [W-1:0] ra, rb;
    logic [2:0]   rt;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_counts", {total_cnt, err_cnt} | illegal_cnt, 0);
    check("rst_first_err", {first_err_valid, first_err_a, first_err_b}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact comparator, back-to-back, latency to done
    model_clear();
    pulse_start(4, sc);
    send(32'h0, 32'h0, 3'b100, a0);
    send(32'h8, 32'h8000_0000, 3'b001, ac);
    send(32'h8000_0000, 32'h8, 3'b010, ac);
    send(32'hF209_0808, 32'hF209_0808, 3'b100, ac);
    push_exp();
    wait_done(dc);
    check("exact_done_latency", dc - a0, 7);
    idle(3);
    check("hold_total_after_done", total_cnt, 4);

    // One legal mismatch then a correct pair
    model_clear();
    pulse_start(2, sc);
    send(32'hC000_0008, 32'h8000_8000, 3'b001, ac);
    send(32'h5, 32'h5, 3'b100, ac);
    push_exp();
    wait_done(dc);

    // Two illegal outputs
    model_clear();
    pulse_start(2, sc);
    send(32'h1, 32'h2, 3'b000, ac);
    send(32'h3, 32'h3, 3'b110, ac);
    push_exp();
    wait_done(dc);

    // Gapped in_valid, in_ready drops after the last transfer
    model_clear();
    pulse_start(3, sc);
    send(32'h10, 32'h20, 3'b001, ac);
    idle(1);
    send(32'h30, 32'h20, 3'b010, ac);
    idle(1);
    send(32'h7, 32'h7, 3'b001, ac);
    @(negedge clk);
    check("in_ready_after_last", in_ready, 0);
    @(posedge clk); #1;
    push_exp();
    wait_done(dc);

    // Zero-length run
    model_clear();
    pulse_start(0, sc);
    push_exp();
    wait_done(dc);
    check("zero_run_done_latency", dc - sc, 1);

    // start during RUN is ignored
    model_clear();
    pulse_start(3, sc);
    send(32'hAA, 32'hAB, 3'b100, ac);
    pulse_start(9, sc);
    send(32'hFFFF_FFFF, 32'h0, 3'b010, ac);
    send(32'h0, 32'hFFFF_FFFF, 3'b001, ac);
    push_exp();
    wait_done(dc);

    // Reset mid-run aborts without done
    model_clear();
    pulse_start(5, sc);
    send(32'h9, 32'h4, 3'b100, ac);
    send(32'h2, 32'h2, 3'b100, ac);
    check("pre_reset_total", total_cnt, 1);
    rst_n = 1'b0;
    #1;
    check("arst_total", total_cnt, 0);
    check("arst_err", err_cnt, 0);
    check("arst_first_err_valid", first_err_valid, 0);
    check("arst_busy_ready", {busy, in_ready, done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle_busy", busy, 0);
    model_clear();
    pulse_start(1, sc);
    send(32'h1234, 32'h1233, 3'b010, ac);
    push_exp();
    wait_done(dc);

    // Randomised runs
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 12);
      model_clear();
      pulse_start(n, sc);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        ra = $urandom;
        case ($urandom_range(0, 2))
          0: rb = ra;
          1: rb = $urandom;
          default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        endcase
        if ($urandom_range(0, 9) < 6) rt = {ra == rb, ra > rb, ra < rb};
        else rt = 3'($urandom_range(0, 7));
        send(ra, rb, rt, ac);
      end
      push_exp();
      wait_done(dc);
    end

    idle(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
